bk_sram_seq: RTL

Backup-RAM save/load sequencer sitting between the cartridge BSRAM dual-port buffer and the HPS SD block interface. It tracks whether the loaded cartridge has a writable save image and sequences 512-byte sector reads and writes through the `SD_RD`/`SD_WR`/`SD_ACK` handshake. Sectors run until the whole `RAM_MASK` range has been transferred. While a load is in progress it holds the console in reset via `LOADING`.

---
 rtl/bk_sram_seq.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bk_sram_seq.sv
// bk_sram_seq: backup-RAM save/load sequencer between the cartridge BSRAM
// buffer and the HPS SD sector interface. Walks 512-byte sectors from LBA 0
// up to RAM_MASK[23:9] using the SD_RD/SD_WR/SD_ACK handshake and holds the
// console in reset (LOADING) while a load runs.
// Optional feature macro: BKRAM_AUTOSAVE_EN (dirty tracking + OSD autosave).
module bk_sram_seq #(
    parameter int TO_W = 24
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DL_ACTIVE,
    input  logic        IMG_MOUNTED,
    input  logic        IMG_SIZE_NZ,
    input  logic        IMG_READONLY,
    input  logic [23:0] RAM_MASK,
    input  logic        LOAD_REQ,
    input  logic        SAVE_REQ,
    input  logic        SD_ACK,
    input  logic        BSRAM_WE,
    input  logic        OSD_STATUS,
    output logic [31:0] SD_LBA,
    output logic        SD_RD,
    output logic        SD_WR,
    output logic        BK_ENA,
    output logic        LOADING,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        DIRTY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            bk_ena_q, bk_ena_d;
    logic            loading_q, loading_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            dl_prev_q, dl_prev_d;
    logic            ack_prev_q, ack_prev_d;
    logic            load_prev_q, load_prev_d;
    logic            save_prev_q, save_prev_d;

    logic [TO_W-1:0] to_inc_s;
    logic            dl_rise_s, dl_fall_s;
    logic            ack_rise_s, ack_fall_s;
    logic            load_edge_s, save_edge_s, autoload_s, autosave_s;
    logic            start_s, start_dir_s;
    logic            last_s;

    // Edge detection on level inputs against their previous-cycle samples
    always_comb begin
        dl_prev_d   = DL_ACTIVE;
        ack_prev_d  = SD_ACK;
        load_prev_d = LOAD_REQ & bk_ena_q;
        save_prev_d = SAVE_REQ & bk_ena_q;
        dl_rise_s   = DL_ACTIVE & ~dl_prev_q;
        dl_fall_s   = ~DL_ACTIVE & dl_prev_q;
        ack_rise_s  = SD_ACK & ~ack_prev_q;
        ack_fall_s  = ~SD_ACK & ack_prev_q;
        load_edge_s = load_prev_d & ~load_prev_q;
        save_edge_s = save_prev_d & ~save_prev_q;
        autoload_s  = dl_fall_s & bk_ena_q;
    end

    // Trigger arbitration: any load source beats save, autosave is lowest
    always_comb begin
        start_dir_s = load_edge_s | autoload_s;
        start_s     = load_edge_s | save_edge_s | autoload_s | autosave_s;
    end

    // Save image usability: cleared by a new ROM download, set by a mount
    always_comb begin
        if (dl_rise_s) begin
            bk_ena_d = 1'b0;
        end else if (DL_ACTIVE && IMG_MOUNTED && IMG_SIZE_NZ && !IMG_READONLY) begin
            bk_ena_d = |RAM_MASK;
        end else begin
            bk_ena_d = bk_ena_q;
        end
    end

    // Sector sequencer next-state, request, timeout and completion logic
    always_comb begin
        to_inc_s  = to_q + {{(TO_W-1){1'b0}}, 1'b1};
        last_s    = (lba_q >= {17'd0, RAM_MASK[23:9]});
        state_d   = state_q;
        dir_d     = dir_q;
        lba_d     = lba_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        loading_d = loading_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        to_d      = to_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    dir_d     = start_dir_s;
                    lba_d     = 32'd0;
                    loading_d = start_dir_s;
                    rd_d      = start_dir_s;
                    wr_d      = ~start_dir_s;
                    to_d      = {TO_W{1'b0}};
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_rise_s) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    to_d    = {TO_W{1'b0}};
                    state_d = ST_XFER;
                end else if (&to_inc_s) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    loading_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_d = to_inc_s;
                end
            end
            ST_XFER: begin
                if (ack_fall_s) begin
                    state_d = ST_NEXT;
                end else if (&to_inc_s) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    loading_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_d = to_inc_s;
                end
            end
            ST_NEXT: begin
                if (last_s) begin
                    loading_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    lba_d   = lba_q + 32'd1;
                    rd_d    = dir_q;
                    wr_d    = ~dir_q;
                    to_d    = {TO_W{1'b0}};
                    state_d = ST_REQ;
                end
            end
            default: begin
                rd_d      = 1'b0;
                wr_d      = 1'b0;
                loading_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // A new ROM download aborts everything silently
        if (dl_rise_s) begin
            state_d   = ST_IDLE;
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            loading_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else begin
            err_d = err_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            lba_q       <= 32'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            bk_ena_q    <= 1'b0;
            loading_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            to_q        <= {TO_W{1'b0}};
            dl_prev_q   <= 1'b0;
            ack_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
            save_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            lba_q       <= lba_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bk_ena_q    <= bk_ena_d;
            loading_q   <= loading_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            to_q        <= to_d;
            dl_prev_q   <= dl_prev_d;
            ack_prev_q  <= ack_prev_d;
            load_prev_q <= load_prev_d;
            save_prev_q <= save_prev_d;
        end
    end

`ifdef BKRAM_AUTOSAVE_EN
    logic dirty_q, dirty_d;
    logic osd_prev_q, osd_prev_d;

    // Dirty tracking (cleared when a transfer starts) and OSD-open autosave
    always_comb begin
        osd_prev_d = OSD_STATUS;
        autosave_s = OSD_STATUS & ~osd_prev_q & dirty_q & bk_ena_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            dirty_d = 1'b0;
        end else if (BSRAM_WE && !loading_q) begin
            dirty_d = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Autosave state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dirty_q    <= 1'b0;
            osd_prev_q <= 1'b0;
        end else begin
            dirty_q    <= dirty_d;
            osd_prev_q <= osd_prev_d;
        end
    end

    assign DIRTY = dirty_q;
`else
    logic unused_s;
    assign unused_s   = BSRAM_WE ^ OSD_STATUS;
    assign autosave_s = 1'b0;
    assign DIRTY      = 1'b0;
`endif

    assign SD_LBA  = lba_q;
    assign SD_RD   = rd_q;
    assign SD_WR   = wr_q;
    assign BK_ENA  = bk_ena_q;
    assign LOADING = loading_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule
